// File: rtl/sdram_cmd_issuer_if.sv
// Request and column-command bus between the request arbiter and the SDRAM command issuer.
// The master drives requests and consumes commands; the issuer is the slave.
interface sdram_cmd_issuer_if #(
  parameter int ROW_WIDTH = 14,
  parameter int COL_WIDTH = 10,
  parameter int ID_WIDTH  = 4,
  parameter int BANK_BITS = 3
);
  logic                 req_valid;
  logic                 req_ready;
  logic [BANK_BITS-1:0] req_bank;
  logic [ROW_WIDTH-1:0] req_row;
  logic [COL_WIDTH-1:0] req_col;
  logic                 req_we;
  logic [ID_WIDTH-1:0]  req_id;

  logic                 cmd_valid;
  logic                 cmd_we;
  logic [BANK_BITS-1:0] cmd_bank;
  logic [COL_WIDTH-1:0] cmd_col;
  logic [ID_WIDTH-1:0]  cmd_id;

  modport master (
    output req_valid, req_bank, req_row, req_col, req_we, req_id,
    input  req_ready, cmd_valid, cmd_we, cmd_bank, cmd_col, cmd_id
  );

  modport slave (
    input  req_valid, req_bank, req_row, req_col, req_we, req_id,
    output req_ready, cmd_valid, cmd_we, cmd_bank, cmd_col, cmd_id
  );
endinterface

// File: rtl/sdram_cmd_issuer.sv
// Opens the requested row through one-cycle PRE/ACT pulses to the bank tracker, then
// issues a single column command; keeps saturating row hit/miss statistics.
module sdram_cmd_issuer #(
  parameter int ROW_WIDTH = 14,
  parameter int COL_WIDTH = 10,
  parameter int ID_WIDTH  = 4,
  parameter int BANKS     = 8,
  parameter int CNT_WIDTH = 16,
  localparam int BANK_BITS = (BANKS > 1) ? $clog2(BANKS) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  sdram_cmd_issuer_if.slave                bus,
  input  logic [BANKS-1:0]                 bank_active_i,
  input  logic [BANKS-1:0]                 bank_blocked_i,
  input  logic [BANKS-1:0][ROW_WIDTH-1:0]  bank_row_i,
  output logic [BANKS-1:0]                 precharge_o,
  output logic [BANKS-1:0]                 activate_o,
  output logic [ROW_WIDTH-1:0]             row_address_o,
  output logic                             err_bank_o,
  output logic [CNT_WIDTH-1:0]             hit_count_o,
  output logic [CNT_WIDTH-1:0]             miss_count_o
);

  typedef enum logic [1:0] {IDLE, DECIDE, WAIT} state_t;

  localparam logic [BANK_BITS:0] BANK_LIMIT = (BANK_BITS + 1)'(BANKS);
  localparam logic [BANKS-1:0]   BANK_ONE   = BANKS'(1);

  state_t               state_q;
  logic                 req_ready_q;
  logic [BANK_BITS-1:0] bank_q;
  logic [ROW_WIDTH-1:0] row_q;
  logic [COL_WIDTH-1:0] col_q;
  logic                 we_q;
  logic [ID_WIDTH-1:0]  id_q;
  logic                 classified_q;

  logic [BANKS-1:0]     precharge_q;
  logic [BANKS-1:0]     activate_q;
  logic [ROW_WIDTH-1:0] row_address_q;
  logic                 cmd_valid_q;
  logic                 cmd_we_q;
  logic [BANK_BITS-1:0] cmd_bank_q;
  logic [COL_WIDTH-1:0] cmd_col_q;
  logic [ID_WIDTH-1:0]  cmd_id_q;
  logic                 err_bank_q;
  logic [CNT_WIDTH-1:0] hit_q;
  logic [CNT_WIDTH-1:0] miss_q;

  logic                 req_fire;
  logic                 req_bank_ok;
  logic                 bank_busy;
  logic                 bank_open;
  logic                 row_match;
  logic [BANKS-1:0]     bank_onehot;
  logic [CNT_WIDTH-1:0] hit_d;
  logic [CNT_WIDTH-1:0] miss_d;

  assign req_fire    = bus.req_valid & req_ready_q;
  assign req_bank_ok = {1'b0, bus.req_bank} < BANK_LIMIT;
  assign bank_busy   = bank_blocked_i[bank_q];
  assign bank_open   = bank_active_i[bank_q];
  assign row_match   = bank_row_i[bank_q] == row_q;
  assign bank_onehot = BANK_ONE << bank_q;

  // Counters hold at all-ones instead of wrapping.
  assign hit_d  = (hit_q == '1)  ? hit_q  : hit_q + CNT_WIDTH'(1);
  assign miss_d = (miss_q == '1) ? miss_q : miss_q + CNT_WIDTH'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      req_ready_q   <= 1'b1;
      bank_q        <= '0;
      row_q         <= '0;
      col_q         <= '0;
      we_q          <= 1'b0;
      id_q          <= '0;
      classified_q  <= 1'b0;
      precharge_q   <= '0;
      activate_q    <= '0;
      row_address_q <= '0;
      cmd_valid_q   <= 1'b0;
      cmd_we_q      <= 1'b0;
      cmd_bank_q    <= '0;
      cmd_col_q     <= '0;
      cmd_id_q      <= '0;
      err_bank_q    <= 1'b0;
      hit_q         <= '0;
      miss_q        <= '0;
    end else begin
      precharge_q <= '0;
      activate_q  <= '0;
      cmd_valid_q <= 1'b0;
      err_bank_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_fire) begin
            if (req_bank_ok) begin
              bank_q       <= bus.req_bank;
              row_q        <= bus.req_row;
              col_q        <= bus.req_col;
              we_q         <= bus.req_we;
              id_q         <= bus.req_id;
              classified_q <= 1'b0;
              req_ready_q  <= 1'b0;
              state_q      <= DECIDE;
            end else begin
              err_bank_q <= 1'b1;
            end
          end
        end
        DECIDE: begin
          if (!bank_busy) begin
            // Only the first unblocked look at the bank decides hit versus miss.
            if (!classified_q) begin
              classified_q <= 1'b1;
              if (bank_open && row_match) hit_q  <= hit_d;
              else                        miss_q <= miss_d;
            end
            if (bank_open && row_match) begin
              cmd_valid_q <= 1'b1;
              cmd_we_q    <= we_q;
              cmd_bank_q  <= bank_q;
              cmd_col_q   <= col_q;
              cmd_id_q    <= id_q;
              req_ready_q <= 1'b1;
              state_q     <= IDLE;
            end else if (bank_open) begin
              precharge_q <= bank_onehot;
              state_q     <= WAIT;
            end else begin
              activate_q    <= bank_onehot;
              row_address_q <= row_q;
              state_q       <= WAIT;
            end
          end
        end
        // One idle cycle so the tracker's registered blocked flag is visible next.
        WAIT:    state_q <= DECIDE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.cmd_valid = cmd_valid_q;
  assign bus.cmd_we    = cmd_we_q;
  assign bus.cmd_bank  = cmd_bank_q;
  assign bus.cmd_col   = cmd_col_q;
  assign bus.cmd_id    = cmd_id_q;

  assign precharge_o   = precharge_q;
  assign activate_o    = activate_q;
  assign row_address_o = row_address_q;
  assign err_bank_o    = err_bank_q;
  assign hit_count_o   = hit_q;
  assign miss_count_o  = miss_q;

endmodule

// File: tb/tb_sdram_cmd_issuer.sv
// Directed bench: an 8-bank issuer driven by a small bank tracker model, plus a 6-bank
// issuer with 3-bit counters for out-of-range banks and counter saturation.
module tb_sdram_cmd_issuer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  sdram_cmd_issuer_if #(.ROW_WIDTH(14), .COL_WIDTH(10), .ID_WIDTH(4), .BANK_BITS(3)) bus8 ();
  sdram_cmd_issuer_if #(.ROW_WIDTH(14), .COL_WIDTH(10), .ID_WIDTH(4), .BANK_BITS(3)) bus6 ();

  // 8-bank DUT signals and tracker model
  logic [7:0]       trk_active;
  logic [7:0]       trk_blocked;
  logic [7:0][13:0] trk_row;
  int               blk_cnt [8];
  logic [7:0]       pre8, act8;
  logic [13:0]      rowaddr8;
  logic             err8;
  logic [15:0]      hit8, miss8;

  logic             pl_en;
  logic [2:0]       pl_bank;
  logic             pl_active;
  logic [13:0]      pl_row;

  // 6-bank DUT: every bank open on row 0, never blocked
  logic [5:0]       act6_in, blk6_in;
  logic [5:0][13:0] row6_in;
  logic [5:0]       pre6, act6;
  logic [13:0]      rowaddr6;
  logic             err6;
  logic [2:0]       hit6, miss6;

  assign act6_in = '1;
  assign blk6_in = '0;
  assign row6_in = '0;

  sdram_cmd_issuer #(.ROW_WIDTH(14), .COL_WIDTH(10), .ID_WIDTH(4), .BANKS(8), .CNT_WIDTH(16)) u_dut8 (
    .clk(clk), .rst(rst), .bus(bus8.slave),
    .bank_active_i(trk_active), .bank_blocked_i(trk_blocked), .bank_row_i(trk_row),
    .precharge_o(pre8), .activate_o(act8), .row_address_o(rowaddr8),
    .err_bank_o(err8), .hit_count_o(hit8), .miss_count_o(miss8)
  );

  sdram_cmd_issuer #(.ROW_WIDTH(14), .COL_WIDTH(10), .ID_WIDTH(4), .BANKS(6), .CNT_WIDTH(3)) u_dut6 (
    .clk(clk), .rst(rst), .bus(bus6.slave),
    .bank_active_i(act6_in), .bank_blocked_i(blk6_in), .bank_row_i(row6_in),
    .precharge_o(pre6), .activate_o(act6), .row_address_o(rowaddr6),
    .err_bank_o(err6), .hit_count_o(hit6), .miss_count_o(miss6)
  );

  // Tracker: ACT opens the row and blocks 9 cycles, PRE closes it and blocks 3 cycles.
  always @(posedge clk) begin
    if (rst) begin
      trk_active <= '0;
      trk_row    <= '0;
      for (int i = 0; i < 8; i++) blk_cnt[i] <= 0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (act8[i]) begin
          trk_active[i] <= 1'b1;
          trk_row[i]    <= rowaddr8;
          blk_cnt[i]    <= 9;
        end else if (pre8[i]) begin
          trk_active[i] <= 1'b0;
          blk_cnt[i]    <= 3;
        end else if (blk_cnt[i] != 0) begin
          blk_cnt[i] <= blk_cnt[i] - 1;
        end
      end
      if (pl_en) begin
        trk_active[pl_bank] <= pl_active;
        trk_row[pl_bank]    <= pl_row;
      end
    end
  end

  always_comb begin
    trk_blocked = '0;
    for (int i = 0; i < 8; i++) trk_blocked[i] = (blk_cnt[i] != 0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [2:0] b, input logic a, input logic [13:0] r);
    pl_en = 1'b1; pl_bank = b; pl_active = a; pl_row = r;
    step();
    pl_en = 1'b0;
  endtask

  // Presents one request for a single cycle; the issuer is ready when this is called.
  task automatic send8(input logic [2:0] b, input logic [13:0] r, input logic [9:0] c,
                       input logic we, input logic [3:0] id);
    bus8.req_valid = 1'b1; bus8.req_bank = b; bus8.req_row = r;
    bus8.req_col = c; bus8.req_we = we; bus8.req_id = id;
    step();
    bus8.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++;
    if (bus8.req_ready !== 1'b1 || bus8.cmd_valid !== 1'b0 || pre8 !== 8'h00 || act8 !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctrl: ready=%0b cmd_valid=%0b pre=%h act=%h, expected 1 0 00 00",
               bus8.req_ready, bus8.cmd_valid, pre8, act8);
    end
    checks++;
    if (hit8 !== 16'd0 || miss8 !== 16'd0 || rowaddr8 !== 14'd0 || err8 !== 1'b0) begin
      errors++;
      $display("FAIL reset_data: hit=%0d miss=%0d row_address=%h err=%0b, expected 0 0 0 0",
               hit8, miss8, rowaddr8, err8);
    end
    rst = 1'b0;
    step();
    $display("reset: done");
  endtask

  task automatic test_hit();
    preload(3'd2, 1'b1, 14'h55);
    send8(3'd2, 14'h55, 10'h3A, 1'b0, 4'd5);
    step();
    checks++;
    if (bus8.cmd_valid !== 1'b1 || bus8.cmd_bank !== 3'd2 || bus8.cmd_we !== 1'b0 ||
        bus8.cmd_col !== 10'h3A || bus8.cmd_id !== 4'd5) begin
      errors++;
      $display("FAIL hit_cmd: valid=%0b bank=%0d we=%0b col=%h id=%0d, expected 1 2 0 03a 5",
               bus8.cmd_valid, bus8.cmd_bank, bus8.cmd_we, bus8.cmd_col, bus8.cmd_id);
    end
    checks++;
    if (bus8.req_ready !== 1'b1 || hit8 !== 16'd1 || miss8 !== 16'd0) begin
      errors++;
      $display("FAIL hit_stats: ready=%0b hit=%0d miss=%0d, expected 1 1 0",
               bus8.req_ready, hit8, miss8);
    end
    step();
    checks++;
    if (bus8.cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL hit_pulse_width: cmd_valid=%0b, expected 0", bus8.cmd_valid);
    end
    $display("hit: bank2 row 55 -> cmd_valid in N+2, hit_count=%0d", hit8);
  endtask

  task automatic test_closed_miss();
    int fall_step = -1;
    int cmd_step  = -1;
    int extra_act = 0;
    bit saw_blk   = 1'b0;
    logic we_seen = 1'b0;
    logic [3:0] id_seen = '0;
    send8(3'd3, 14'h10, 10'h11, 1'b1, 4'd9);
    step();
    checks++;
    if (act8 !== 8'h08 || rowaddr8 !== 14'h10 || pre8 !== 8'h00) begin
      errors++;
      $display("FAIL closed_act: act=%h row_address=%h pre=%h, expected 08 0010 00",
               act8, rowaddr8, pre8);
    end
    for (int s = 1; s <= 40 && cmd_step < 0; s++) begin
      step();
      if (act8 != 8'h00) extra_act++;
      if (trk_blocked[3]) saw_blk = 1'b1;
      else if (saw_blk && fall_step < 0) fall_step = s;
      if (bus8.cmd_valid) begin
        cmd_step = s; we_seen = bus8.cmd_we; id_seen = bus8.cmd_id;
      end
    end
    checks++;
    if (cmd_step != 11 || fall_step != 10) begin
      errors++;
      $display("FAIL closed_timing: blocked fell at step %0d, cmd at step %0d, expected 10 and 11",
               fall_step, cmd_step);
    end
    checks++;
    if (extra_act != 0 || we_seen !== 1'b1 || id_seen !== 4'd9) begin
      errors++;
      $display("FAIL closed_cmd: extra activates=%0d we=%0b id=%0d, expected 0 1 9",
               extra_act, we_seen, id_seen);
    end
    checks++;
    if (miss8 !== 16'd1 || hit8 !== 16'd1) begin
      errors++;
      $display("FAIL closed_stats: hit=%0d miss=%0d, expected 1 1", hit8, miss8);
    end
    $display("closed_miss: bank3 row 10 -> cmd at step %0d, miss_count=%0d", cmd_step, miss8);
  endtask

  task automatic test_conflict();
    int act_step = -1;
    int cmd_step = -1;
    int act_cnt  = 0;
    int pre_cnt  = 0;
    int bad      = 0;
    preload(3'd1, 1'b1, 14'h20);
    send8(3'd1, 14'h21, 10'h07, 1'b0, 4'd3);
    step();
    checks++;
    if (pre8 !== 8'h02 || act8 !== 8'h00) begin
      errors++;
      $display("FAIL conflict_pre: pre=%h act=%h, expected 02 00", pre8, act8);
    end
    for (int s = 1; s <= 60 && cmd_step < 0; s++) begin
      step();
      if (pre8 != 8'h00) pre_cnt++;
      if (act8 != 8'h00) begin
        act_cnt++;
        act_step = s;
        if (act8 !== 8'h02 || rowaddr8 !== 14'h21) bad++;
      end
      if (bus8.cmd_valid && ((pre8 | act8) != 8'h00)) bad++;
      if (!$onehot0(pre8 | act8)) bad++;
      if (bus8.cmd_valid) cmd_step = s;
    end
    checks++;
    if (act_step != 5 || cmd_step != 16) begin
      errors++;
      $display("FAIL conflict_timing: act at step %0d, cmd at step %0d, expected 5 and 16",
               act_step, cmd_step);
    end
    checks++;
    if (act_cnt != 1 || pre_cnt != 0 || bad != 0) begin
      errors++;
      $display("FAIL conflict_pulses: act=%0d extra pre=%0d bad cycles=%0d, expected 1 0 0",
               act_cnt, pre_cnt, bad);
    end
    checks++;
    if (miss8 !== 16'd2 || hit8 !== 16'd1) begin
      errors++;
      $display("FAIL conflict_stats: hit=%0d miss=%0d, expected 1 2", hit8, miss8);
    end
    $display("conflict: bank1 row 20->21 -> act step %0d cmd step %0d", act_step, cmd_step);
  endtask

  task automatic test_back_to_back();
    send8(3'd2, 14'h55, 10'h01, 1'b0, 4'd1);
    step();
    checks++;
    if (bus8.cmd_valid !== 1'b1 || bus8.cmd_id !== 4'd1 || bus8.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first: cmd_valid=%0b id=%0d ready=%0b, expected 1 1 1",
               bus8.cmd_valid, bus8.cmd_id, bus8.req_ready);
    end
    send8(3'd2, 14'h55, 10'h02, 1'b1, 4'd2);
    checks++;
    if (bus8.cmd_valid !== 1'b0 || bus8.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap: cmd_valid=%0b ready=%0b, expected 0 0", bus8.cmd_valid, bus8.req_ready);
    end
    step();
    checks++;
    if (bus8.cmd_valid !== 1'b1 || bus8.cmd_id !== 4'd2 || bus8.cmd_we !== 1'b1 || hit8 !== 16'd3) begin
      errors++;
      $display("FAIL b2b_second: cmd_valid=%0b id=%0d we=%0b hit=%0d, expected 1 2 1 3",
               bus8.cmd_valid, bus8.cmd_id, bus8.cmd_we, hit8);
    end
    $display("back_to_back: two hits, hit_count=%0d", hit8);
  endtask

  task automatic test_reset_mid_wait();
    int pulses = 0;
    send8(3'd4, 14'h44, 10'h04, 1'b0, 4'd4);
    step();
    checks++;
    if (act8 !== 8'h10) begin
      errors++;
      $display("FAIL midwait_act: act=%h, expected 10", act8);
    end
    rst = 1'b1;
    step();
    checks++;
    if (bus8.req_ready !== 1'b1 || pre8 !== 8'h00 || act8 !== 8'h00 || bus8.cmd_valid !== 1'b0 ||
        hit8 !== 16'd0 || miss8 !== 16'd0) begin
      errors++;
      $display("FAIL midwait_reset: ready=%0b pre=%h act=%h cmd=%0b hit=%0d miss=%0d, expected 1 00 00 0 0 0",
               bus8.req_ready, pre8, act8, bus8.cmd_valid, hit8, miss8);
    end
    rst = 1'b0;
    for (int s = 0; s < 20; s++) begin
      step();
      if (pre8 != 8'h00 || act8 != 8'h00 || bus8.cmd_valid || !bus8.req_ready) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL midwait_quiet: %0d cycles with activity after reset, expected 0", pulses);
    end
    $display("reset_mid_wait: request dropped");
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 9; i++) begin
      bus6.req_valid = 1'b1; bus6.req_bank = 3'd0; bus6.req_row = 14'h0;
      bus6.req_col = 10'(i); bus6.req_we = 1'b0; bus6.req_id = 4'(i);
      step();
      bus6.req_valid = 1'b0;
      step();
      if (i == 5) begin
        checks++;
        if (hit6 !== 3'd6) begin
          errors++;
          $display("FAIL sat_count: hit=%0d after 6 hits, expected 6", hit6);
        end
      end
    end
    checks++;
    if (hit6 !== 3'd7 || miss6 !== 3'd0) begin
      errors++;
      $display("FAIL sat_hold: hit=%0d miss=%0d after 9 hits, expected 7 0", hit6, miss6);
    end
    $display("saturation: 9 hits into 3-bit counter -> %0d", hit6);
  endtask

  task automatic test_err_bank();
    int cmds = 0;
    bus6.req_valid = 1'b1; bus6.req_bank = 3'd7; bus6.req_row = 14'h0;
    bus6.req_col = 10'h0; bus6.req_we = 1'b1; bus6.req_id = 4'hF;
    step();
    bus6.req_valid = 1'b0;
    checks++;
    if (err6 !== 1'b1 || bus6.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL err_pulse: err_bank=%0b ready=%0b, expected 1 1", err6, bus6.req_ready);
    end
    for (int s = 0; s < 5; s++) begin
      step();
      if (bus6.cmd_valid || err6 || pre6 != 6'd0 || act6 != 6'd0) cmds++;
    end
    checks++;
    if (cmds != 0 || hit6 !== 3'd7 || miss6 !== 3'd0) begin
      errors++;
      $display("FAIL err_drop: activity cycles=%0d hit=%0d miss=%0d, expected 0 7 0", cmds, hit6, miss6);
    end
    $display("err_bank: bank 7 of 6 dropped");
  endtask

  initial begin
    rst = 1'b1;
    pl_en = 1'b0; pl_bank = '0; pl_active = 1'b0; pl_row = '0;
    bus8.req_valid = 1'b0; bus8.req_bank = '0; bus8.req_row = '0;
    bus8.req_col = '0; bus8.req_we = 1'b0; bus8.req_id = '0;
    bus6.req_valid = 1'b0; bus6.req_bank = '0; bus6.req_row = '0;
    bus6.req_col = '0; bus6.req_we = 1'b0; bus6.req_id = '0;
    test_reset();
    test_hit();
    test_closed_miss();
    test_conflict();
    test_back_to_back();
    test_reset_mid_wait();
    test_saturation();
    test_err_bank();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
